// File: rtl/dcpu16_pkg.sv
// Shared types and constants for the DCPU16 memory-side bus logic.
package dcpu16_pkg;

    // Bus arbiter transfer phases.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Master port identifiers; also used as bit positions in the request vector.
    localparam logic MST_FS = 1'b0;
    localparam logic MST_AB = 1'b1;

    // Read data returned to a master when the slave never answers.
    localparam logic [15:0] BUS_ERR_DATA = 16'hFFFF;

endpackage

// File: rtl/dcpu16_rr_arb.sv
// Two-way round-robin picker: on contention serve the port not served last,
// otherwise serve whichever port is asking. Purely combinational.
module dcpu16_rr_arb
    import dcpu16_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    // Winner selection from the current requests and the previous grant.
    always_comb begin
        valid = |req;
        gnt   = MST_FS;
        if (req == 2'b11) begin
            gnt = ~last;
        end else if (req[MST_AB]) begin
            gnt = MST_AB;
        end
    end

endmodule

// File: rtl/dcpu16_mbus.sv
// Merges the DCPU16 FBUS and ABUS master ports onto a single Wishbone-classic
// memory port, one transfer at a time, with a watchdog on the slave ack.
module dcpu16_mbus
    import dcpu16_pkg::*;
#(
    parameter int TMO = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs_stb,
    input  logic        fs_wre,
    input  logic [15:0] fs_adr,
    input  logic [15:0] fs_dto,
    output logic [15:0] fs_dti,
    output logic        fs_ack,
    input  logic        ab_stb,
    input  logic        ab_wre,
    input  logic [15:0] ab_adr,
    input  logic [15:0] ab_dto,
    output logic [15:0] ab_dti,
    output logic        ab_ack,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [15:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        bus_err
);

    // Watchdog counter width; one spare bit on the incremented value keeps the
    // limit compare free of wrap-around.
    localparam int          CW      = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [CW:0] TMO_LIM = (CW + 1)'(TMO);

    state_t        state, state_nxt;
    logic          win, win_nxt;
    logic          last_gnt, last_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW:0]   cnt_inc;

    logic          cyc_nxt, we_nxt;
    logic [15:0]   adr_nxt, dat_nxt;
    logic [15:0]   fs_dti_nxt, ab_dti_nxt;
    logic          fs_ack_nxt, ab_ack_nxt, err_nxt;

    logic          arb_gnt, arb_valid;

    dcpu16_rr_arb u_arb (
        .req   ({ab_stb, fs_stb}),
        .last  (last_gnt),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    assign wb_stb_o = wb_cyc_o;
    assign cnt_inc  = {1'b0, cnt} + 1'b1;

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_nxt  = state;
        win_nxt    = win;
        last_nxt   = last_gnt;
        cnt_nxt    = cnt;
        cyc_nxt    = wb_cyc_o;
        we_nxt     = wb_we_o;
        adr_nxt    = wb_adr_o;
        dat_nxt    = wb_dat_o;
        fs_dti_nxt = fs_dti;
        ab_dti_nxt = ab_dti;
        fs_ack_nxt = 1'b0;
        ab_ack_nxt = 1'b0;
        err_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (arb_valid) begin
                    win_nxt   = arb_gnt;
                    last_nxt  = arb_gnt;
                    cnt_nxt   = '0;
                    cyc_nxt   = 1'b1;
                    we_nxt    = (arb_gnt == MST_AB) ? ab_wre : fs_wre;
                    adr_nxt   = (arb_gnt == MST_AB) ? ab_adr : fs_adr;
                    dat_nxt   = (arb_gnt == MST_AB) ? ab_dto : fs_dto;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (wb_ack_i) begin
                    cyc_nxt   = 1'b0;
                    state_nxt = DONE;
                    if (win == MST_AB) begin
                        ab_ack_nxt = 1'b1;
                        if (!wb_we_o) ab_dti_nxt = wb_dat_i;
                    end else begin
                        fs_ack_nxt = 1'b1;
                        if (!wb_we_o) fs_dti_nxt = wb_dat_i;
                    end
                end else if (TMO != 0) begin
                    if (cnt_inc == TMO_LIM) begin
                        cyc_nxt   = 1'b0;
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                        if (win == MST_AB) begin
                            ab_ack_nxt = 1'b1;
                            if (!wb_we_o) ab_dti_nxt = BUS_ERR_DATA;
                        end else begin
                            fs_ack_nxt = 1'b1;
                            if (!wb_we_o) fs_dti_nxt = BUS_ERR_DATA;
                        end
                    end else begin
                        cnt_nxt = cnt_inc[CW-1:0];
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, bus and master-facing registers; reset clears every output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            win      <= MST_FS;
            last_gnt <= MST_AB;
            cnt      <= '0;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            fs_dti   <= '0;
            ab_dti   <= '0;
            fs_ack   <= 1'b0;
            ab_ack   <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            win      <= win_nxt;
            last_gnt <= last_nxt;
            cnt      <= cnt_nxt;
            wb_cyc_o <= cyc_nxt;
            wb_we_o  <= we_nxt;
            wb_adr_o <= adr_nxt;
            wb_dat_o <= dat_nxt;
            fs_dti   <= fs_dti_nxt;
            ab_dti   <= ab_dti_nxt;
            fs_ack   <= fs_ack_nxt;
            ab_ack   <= ab_ack_nxt;
            bus_err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_dcpu16_mbus.sv
// Bench for dcpu16_mbus: transaction-level reference model, a simple memory
// slave with programmable ack latency, and directed master scenarios.
module tb_dcpu16_mbus;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fs_stb = 1'b0, fs_wre = 1'b0;
    logic [15:0] fs_adr = '0, fs_dto = '0;
    logic [15:0] fs_dti;
    logic        fs_ack;
    logic        ab_stb = 1'b0, ab_wre = 1'b0;
    logic [15:0] ab_adr = '0, ab_dto = '0;
    logic [15:0] ab_dti;
    logic        ab_ack;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [15:0] wb_adr_o, wb_dat_o;
    logic [15:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        bus_err;

    dcpu16_mbus #(.TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .fs_stb(fs_stb), .fs_wre(fs_wre), .fs_adr(fs_adr), .fs_dto(fs_dto),
        .fs_dti(fs_dti), .fs_ack(fs_ack),
        .ab_stb(ab_stb), .ab_wre(ab_wre), .ab_adr(ab_adr), .ab_dto(ab_dto),
        .ab_dti(ab_dti), .ab_ack(ab_ack),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;
    bit started = 0;

    function automatic void chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // ---------------- memory slave ----------------
    logic [15:0] mem [logic [15:0]];
    int slave_lat = 1;   // 0 = never acknowledge
    int scnt = 0;
    bit sacked = 0;

    function automatic logic [15:0] rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 16'h5A00;
    endfunction

    always @(negedge clk) begin
        wb_ack_i = 1'b0;
        if (wb_cyc_o) begin
            if (!sacked) begin
                scnt++;
                if (slave_lat != 0 && scnt == slave_lat) begin
                    wb_ack_i = 1'b1;
                    sacked   = 1;
                    if (wb_we_o) mem[wb_adr_o] = wb_dat_o;
                    else wb_dat_i = rd(wb_adr_o);
                end
            end
        end else begin
            scnt   = 0;
            sacked = 0;
        end
    end

    // ---------------- reference model ----------------
    // One transfer in flight at most; the cycle after completion is the ack
    // cycle, during which no request is looked at.
    bit          m_busy, m_cool, m_last_ab, m_own_ab;
    int          m_wait;
    logic        e_cyc, e_we, e_fack, e_aack, e_err;
    logic [15:0] e_adr, e_dat, e_fdti, e_adti;

    task automatic m_finish(input logic [15:0] rdata, input bit err);
        m_busy = 0;
        m_cool = 1;
        e_cyc  = 0;
        e_err  = err;
        if (m_own_ab) begin
            e_aack = 1;
            if (!e_we) e_adti = rdata;
        end else begin
            e_fack = 1;
            if (!e_we) e_fdti = rdata;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_cool = 0; m_last_ab = 1; m_own_ab = 0; m_wait = 0;
            e_cyc = 0; e_we = 0; e_adr = '0; e_dat = '0;
            e_fdti = '0; e_adti = '0; e_fack = 0; e_aack = 0; e_err = 0;
        end else begin
            e_fack = 0; e_aack = 0; e_err = 0;
            if (m_cool) begin
                m_cool = 0;
            end else if (m_busy) begin
                if (wb_ack_i) m_finish(wb_dat_i, 0);
                else begin
                    m_wait++;
                    if (TMO != 0 && m_wait == TMO) m_finish(16'hFFFF, 1);
                end
            end else if (fs_stb || ab_stb) begin
                m_own_ab  = (fs_stb && ab_stb) ? !m_last_ab : ab_stb;
                m_last_ab = m_own_ab;
                m_busy    = 1;
                m_wait    = 0;
                e_cyc     = 1;
                e_we      = m_own_ab ? ab_wre : fs_wre;
                e_adr     = m_own_ab ? ab_adr : fs_adr;
                e_dat     = m_own_ab ? ab_dto : fs_dto;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("cycle_outputs",
                {fs_ack, ab_ack, bus_err, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, fs_dti, ab_dti},
                {e_fack, e_aack, e_err, e_cyc, e_cyc, e_we, e_adr, e_dat, e_fdti, e_adti});
        end
    end

    // ---------------- transfer monitor ----------------
    logic [15:0] order[$];
    int   xfers = 0;
    logic prev_cyc = 1'b0;

    always @(negedge clk) begin
        if (wb_cyc_o && !prev_cyc) begin
            order.push_back(wb_adr_o);
            xfers++;
        end
        prev_cyc = wb_cyc_o;
    end

    // ---------------- master helper ----------------
    task automatic master(input bit ab, input bit we, input logic [15:0] adr, input logic [15:0] dat,
                          output logic [15:0] dti, output logic err);
        int   n = 0;
        logic ack;
        if (ab) begin ab_stb = 1; ab_wre = we; ab_adr = adr; ab_dto = dat; end
        else    begin fs_stb = 1; fs_wre = we; fs_adr = adr; fs_dto = dat; end
        do begin
            @(negedge clk);
            n++;
            ack = ab ? ab_ack : fs_ack;
        end while (!ack && n < 100);
        chk(ab ? "ab_ack_seen" : "fs_ack_seen", ack, 1);
        dti = ab ? ab_dti : fs_dti;
        err = bus_err;
        if (ab) ab_stb = 0; else fs_stb = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    logic [15:0] d1, d2;
    logic        e1, e2;
    int          n, cyc_cnt, x0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {fs_ack, ab_ack, bus_err, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, fs_dti, ab_dti}, '0);
        rst = 0;
        started = 1;
        @(negedge clk);

        // Contention from reset: FS first, then strict alternation
        slave_lat = 1;
        order.delete();
        fork
            begin
                master(0, 0, 16'h0001, 16'h0, d1, e1);
                master(0, 0, 16'h0011, 16'h0, d1, e1);
            end
            begin
                master(1, 0, 16'h0002, 16'h0, d2, e2);
                master(1, 0, 16'h0012, 16'h0, d2, e2);
            end
        join
        chk("rr_count", order.size(), 4);
        if (order.size() == 4) begin
            chk("rr_0_fs", order[0], 16'h0001);
            chk("rr_1_ab", order[1], 16'h0002);
            chk("rr_2_fs", order[2], 16'h0011);
            chk("rr_3_ab", order[3], 16'h0012);
        end
        chk("rr_fs_dti", d1, 16'h5A11);
        chk("rr_ab_dti", d2, 16'h5A12);
        @(negedge clk);

        // Single FS read, one-cycle slave
        mem[16'h0010] = 16'h1234;
        fs_stb = 1; fs_wre = 0; fs_adr = 16'h0010; fs_dto = 16'h0;
        @(negedge clk);
        chk("rd_stb_next", {wb_stb_o, wb_we_o, wb_adr_o}, {1'b1, 1'b0, 16'h0010});
        @(negedge clk);
        chk("rd_ack", {fs_ack, ab_ack, fs_dti}, {1'b1, 1'b0, 16'h1234});
        fs_stb = 0;
        @(negedge clk);
        chk("rd_ack_single", fs_ack, 0);

        // AB write leaves ab_dti untouched
        slave_lat = 2;
        ab_stb = 1; ab_wre = 1; ab_adr = 16'h8000; ab_dto = 16'hBEEF;
        @(negedge clk);
        chk("wr_issue", {wb_we_o, wb_adr_o, wb_dat_o}, {1'b1, 16'h8000, 16'hBEEF});
        n = 0;
        do begin @(negedge clk); n++; end while (!ab_ack && n < 100);
        chk("wr_ack", {ab_ack, ab_dti, bus_err}, {1'b1, 16'h5A12, 1'b0});
        ab_stb = 0; ab_wre = 0;
        @(negedge clk);
        slave_lat = 1;
        master(0, 0, 16'h8000, 16'h0, d1, e1);
        chk("wr_readback", d1, 16'hBEEF);

        // Dead slave: watchdog expiry
        slave_lat = 0;
        fs_stb = 1; fs_wre = 0; fs_adr = 16'h0020;
        n = 0; cyc_cnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (wb_cyc_o) cyc_cnt++;
        end while (!fs_ack && n < 100);
        chk("tmo_ack", fs_ack, 1);
        chk("tmo_cycles", cyc_cnt, 15);
        chk("tmo_err_dti", {bus_err, fs_dti}, {1'b1, 16'hFFFF});
        fs_stb = 0;
        @(negedge clk);
        chk("tmo_err_pulse", bus_err, 0);
        slave_lat = 1;
        master(0, 0, 16'h0021, 16'h0, d1, e1);
        chk("post_tmo_read", {e1, d1}, {1'b0, 16'h5A21});

        // stb held through the ack cycle: one transfer only
        x0 = xfers;
        fs_stb = 1; fs_wre = 0; fs_adr = 16'h0030;
        n = 0;
        do begin @(negedge clk); n++; end while (!fs_ack && n < 100);
        chk("hold_ack", {fs_ack, fs_dti}, {1'b1, 16'h5A30});
        @(negedge clk);
        fs_stb = 0;
        repeat (4) @(negedge clk);
        chk("hold_single_xfer", xfers - x0, 1);

        // Reset in the middle of a transfer
        slave_lat = 0;
        fs_stb = 1; fs_wre = 0; fs_adr = 16'h0040;
        repeat (3) @(negedge clk);
        chk("pre_rst_cyc", wb_cyc_o, 1);
        #2;
        rst = 1;
        fs_stb = 0;
        #1;
        chk("rst_async_outputs",
            {fs_ack, ab_ack, bus_err, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, fs_dti, ab_dti}, '0);
        repeat (2) @(negedge clk);
        rst = 0;
        slave_lat = 1;
        order.delete();
        fork
            master(0, 0, 16'h0050, 16'h0, d1, e1);
            master(1, 0, 16'h0060, 16'h0, d2, e2);
        join
        chk("post_rst_count", order.size(), 2);
        if (order.size() == 2) begin
            chk("post_rst_fs_first", order[0], 16'h0050);
            chk("post_rst_ab_next", order[1], 16'h0060);
        end
        repeat (2) @(negedge clk);

        started = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
